// File: rtl/cmu_dt_coef_gen_if.sv
// Shared multiplier bus used by cmu_dt_coef_gen.
// The coefficient generator is the master: it presents one operand pair with a
// single-cycle mul_valid strobe. The multiplier (slave) returns mul_result
// together with a single-cycle mul_finish pulse some cycles later.
//   mul_valid  : master -> slave, operand pair valid this cycle
//   mul_a/b    : master -> slave, IEEE-754 double operands
//   mul_finish : slave -> master, result valid this cycle
//   mul_result : slave -> master, rounded product (round-to-nearest-even)
interface cmu_dt_coef_gen_if #(
  parameter int DBL_WIDTH = 64
);
  logic                 mul_valid;
  logic [DBL_WIDTH-1:0] mul_a;
  logic [DBL_WIDTH-1:0] mul_b;
  logic                 mul_finish;
  logic [DBL_WIDTH-1:0] mul_result;

  modport master (
    output mul_valid, mul_a, mul_b,
    input  mul_finish, mul_result
  );

  modport slave (
    input  mul_valid, mul_a, mul_b,
    output mul_finish, mul_result
  );
endinterface

// File: rtl/cmu_dt_coef_gen.sv
// cmu_dt_coef_gen
// Derives the CMU time coefficients from one double-precision time step:
//   delta_t, half_dt2 = dt^2/2, two3_dt3 = 2/3*dt^3, sixth_dt4 = dt^4/6
// using a single external multiplier, issued six times in sequence.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start           : request a computation (only honoured when idle)
//   delta_t_in      : new time step
//   mul             : multiplier bus (master side)
//   busy            : high whenever the sequencer is not idle
//   delta_t..sixth_dt4 : registered coefficients, change only when valid_out pulses
//   valid_out       : one-cycle pulse, coefficients were just updated
//   err             : one-cycle pulse, input rejected or multiplier timed out
// The last accepted dt is cached; restarting with the identical bit pattern
// replays the held outputs without touching the multiplier.
module cmu_dt_coef_gen #(
  parameter int DBL_WIDTH    = 64,
  parameter int WAIT_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DBL_WIDTH-1:0] delta_t_in,
  cmu_dt_coef_gen_if.master    mul,
  output logic                 busy,
  output logic [DBL_WIDTH-1:0] delta_t,
  output logic [DBL_WIDTH-1:0] half_dt2,
  output logic [DBL_WIDTH-1:0] two3_dt3,
  output logic [DBL_WIDTH-1:0] sixth_dt4,
  output logic                 valid_out,
  output logic                 err
);

  localparam int EXP_W = 11;
  localparam int TMO_W = $clog2(WAIT_TIMEOUT + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(WAIT_TIMEOUT - 1);
  localparam logic [DBL_WIDTH-1:0] C_HALF  = DBL_WIDTH'(64'h3FE0000000000000);
  localparam logic [DBL_WIDTH-1:0] C_TWO3  = DBL_WIDTH'(64'h3FE5555555555555);
  localparam logic [DBL_WIDTH-1:0] C_SIXTH = DBL_WIDTH'(64'h3FC5555555555555);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t               state_reg, state_next;
  logic [2:0]           op_idx_reg;
  logic [TMO_W-1:0]     tmo_reg;
  logic                 cache_valid_reg;
  logic                 err_reg;
  logic [DBL_WIDTH-1:0] dt_reg, d2_reg, d3_reg, d4_reg, h2_reg, t3_reg;
  logic [DBL_WIDTH-1:0] delta_t_reg, half_dt2_reg, two3_dt3_reg, sixth_dt4_reg;

  logic                 bad_input;
  logic                 reject;
  logic                 accept;
  logic                 timeout;
  logic                 last_done;
  logic [DBL_WIDTH-1:0] op_a, op_b;

  // Negative numbers (including -0.0), infinities and NaNs are refused.
  assign bad_input = delta_t_in[DBL_WIDTH-1] | (&delta_t_in[DBL_WIDTH-2 -: EXP_W]);

  always_comb begin
    state_next = state_reg;
    reject     = 1'b0;
    accept     = 1'b0;
    timeout    = 1'b0;
    last_done  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) begin
          if (bad_input) begin
            reject = 1'b1;
          end else if (cache_valid_reg && (delta_t_in == delta_t_reg)) begin
            state_next = S_DONE;
          end else begin
            accept     = 1'b1;
            state_next = S_ISSUE;
          end
        end
      end
      S_ISSUE: state_next = S_WAIT;
      S_WAIT: begin
        if (mul.mul_finish) begin
          if (op_idx_reg == 3'd5) begin
            last_done  = 1'b1;
            state_next = S_DONE;
          end else begin
            state_next = S_ISSUE;
          end
        end else if (tmo_reg == TMO_LAST) begin
          timeout    = 1'b1;
          state_next = S_IDLE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Operand selection: powers first, then scaling by the constant factors.
  always_comb begin
    op_a = dt_reg;
    op_b = dt_reg;
    case (op_idx_reg)
      3'd0: begin op_a = dt_reg; op_b = dt_reg;  end
      3'd1: begin op_a = d2_reg; op_b = dt_reg;  end
      3'd2: begin op_a = d3_reg; op_b = dt_reg;  end
      3'd3: begin op_a = d2_reg; op_b = C_HALF;  end
      3'd4: begin op_a = d3_reg; op_b = C_TWO3;  end
      3'd5: begin op_a = d4_reg; op_b = C_SIXTH; end
      default: begin op_a = dt_reg; op_b = dt_reg; end
    endcase
  end

  assign mul.mul_valid = (state_reg == S_ISSUE);
  assign mul.mul_a     = op_a;
  assign mul.mul_b     = op_b;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      op_idx_reg      <= 3'd0;
      tmo_reg         <= '0;
      cache_valid_reg <= 1'b0;
      err_reg         <= 1'b0;
      dt_reg          <= '0;
      d2_reg          <= '0;
      d3_reg          <= '0;
      d4_reg          <= '0;
      h2_reg          <= '0;
      t3_reg          <= '0;
      delta_t_reg     <= '0;
      half_dt2_reg    <= '0;
      two3_dt3_reg    <= '0;
      sixth_dt4_reg   <= '0;
    end else begin
      state_reg <= state_next;
      err_reg   <= reject | timeout;

      if (accept) begin
        dt_reg     <= delta_t_in;
        op_idx_reg <= 3'd0;
      end

      // Counter restarts each time a new WAIT begins.
      if (state_reg == S_ISSUE) begin
        tmo_reg <= '0;
      end else if (state_reg == S_WAIT) begin
        tmo_reg <= tmo_reg + 1'b1;
      end

      if ((state_reg == S_WAIT) && mul.mul_finish) begin
        case (op_idx_reg)
          3'd0: d2_reg <= mul.mul_result;
          3'd1: d3_reg <= mul.mul_result;
          3'd2: d4_reg <= mul.mul_result;
          3'd3: h2_reg <= mul.mul_result;
          3'd4: t3_reg <= mul.mul_result;
          default: ;
        endcase
        if (op_idx_reg != 3'd5) begin
          op_idx_reg <= op_idx_reg + 3'd1;
        end
      end

      // The final product goes straight to the output so that every
      // coefficient becomes visible in the same cycle valid_out pulses.
      if (last_done) begin
        delta_t_reg   <= dt_reg;
        half_dt2_reg  <= h2_reg;
        two3_dt3_reg  <= t3_reg;
        sixth_dt4_reg <= mul.mul_result;
      end

      if (timeout) begin
        cache_valid_reg <= 1'b0;
      end else if (state_reg == S_DONE) begin
        cache_valid_reg <= 1'b1;
      end
    end
  end

  assign busy      = (state_reg != S_IDLE);
  assign valid_out = (state_reg == S_DONE);
  assign err       = err_reg;
  assign delta_t   = delta_t_reg;
  assign half_dt2  = half_dt2_reg;
  assign two3_dt3  = two3_dt3_reg;
  assign sixth_dt4 = sixth_dt4_reg;

endmodule

// File: tb/tb_cmu_dt_coef_gen.sv
// Testbench for cmu_dt_coef_gen: multiplier model on the bus, scoreboard queue
// filled by the driver, monitor popping on every valid_out / err pulse.
module tb_cmu_dt_coef_gen;
  localparam int W = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  delta_t_in;
  logic          busy, valid_out, err;
  logic [W-1:0]  delta_t, half_dt2, two3_dt3, sixth_dt4;

  cmu_dt_coef_gen_if #(.DBL_WIDTH(W)) mif ();

  cmu_dt_coef_gen #(.DBL_WIDTH(W), .WAIT_TIMEOUT(64)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .delta_t_in (delta_t_in),
    .mul        (mif),
    .busy       (busy),
    .delta_t    (delta_t),
    .half_dt2   (half_dt2),
    .two3_dt3   (two3_dt3),
    .sixth_dt4  (sixth_dt4),
    .valid_out  (valid_out),
    .err        (err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp_v);
    end
  endtask

  function automatic logic [W-1:0] fmul(input logic [W-1:0] a, input logic [W-1:0] b);
    return $realtobits($bitstoreal(a) * $bitstoreal(b));
  endfunction

  // ---------------- multiplier model: finish exactly mul_lat cycles after valid
  int           mul_lat    = 2;
  bit           stall      = 1'b0;
  int           mul_cnt    = 0;
  int           mul_issued = 0;
  logic [W-1:0] pend;

  always @(posedge clk) begin
    mif.mul_finish <= 1'b0;
    if (mif.mul_valid === 1'b1) begin
      mul_issued <= mul_issued + 1;
      pend       <= fmul(mif.mul_a, mif.mul_b);
      if (mul_lat == 1) begin
        if (!stall) begin
          mif.mul_finish <= 1'b1;
          mif.mul_result <= fmul(mif.mul_a, mif.mul_b);
        end
      end else begin
        mul_cnt <= mul_lat - 1;
      end
    end else if (mul_cnt > 0) begin
      mul_cnt <= mul_cnt - 1;
      if (mul_cnt == 1 && !stall) begin
        mif.mul_finish <= 1'b1;
        mif.mul_result <= pend;
      end
    end
  end

  // ---------------- reference model + scoreboard
  typedef struct {
    bit           is_err;
    logic [W-1:0] dt, h, t, s;
  } exp_t;

  exp_t         sb_q[$];
  bit           m_cache_valid = 1'b0;
  logic [W-1:0] m_dt = '0, m_h = '0, m_t = '0, m_s = '0;
  int           ev_count = 0;
  int           ev_cyc   = 0;

  always @(negedge clk) begin
    if (rst === 1'b0 && (valid_out === 1'b1 || err === 1'b1)) begin
      ev_count++;
      ev_cyc = cyc;
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: valid_out=%0b err=%0b, required no output pulse", valid_out, err);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("err_pulse",  W'(err),       W'(e.is_err));
        chk("valid_out",  W'(valid_out), W'(!e.is_err));
        chk("busy_at_ev", W'(busy),      W'(!e.is_err));
        chk("delta_t",    delta_t,   e.dt);
        chk("half_dt2",   half_dt2,  e.h);
        chk("two3_dt3",   two3_dt3,  e.t);
        chk("sixth_dt4",  sixth_dt4, e.s);
      end
    end
  end

  int t0;

  task automatic do_start(input logic [W-1:0] dt);
    @(negedge clk);
    start      = 1'b1;
    delta_t_in = dt;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_event(input int ev0, input int bound, input string name);
    for (int i = 0; i < bound && ev_count == ev0; i++) @(posedge clk);
    if (ev_count == ev0) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no valid_out/err within %0d cycles, required one", name, bound);
    end
  endtask

  // One complete request; the model decides reject / hit / miss from the rules.
  task automatic run(input logic [W-1:0] dt);
    exp_t e;
    int   exp_lat, exp_muls, m0, ev0;
    real  d, d2, d3, d4;
    if (dt[63] || dt[62:52] == 11'h7FF) begin
      e = '{1'b1, m_dt, m_h, m_t, m_s};
      exp_lat = 1; exp_muls = 0;
    end else if (m_cache_valid && dt == m_dt) begin
      e = '{1'b0, m_dt, m_h, m_t, m_s};
      exp_lat = 1; exp_muls = 0;
    end else begin
      d  = $bitstoreal(dt);
      d2 = d * d;
      d3 = d2 * d;
      d4 = d3 * d;
      m_dt = dt;
      m_h  = $realtobits(d2 * 0.5);
      m_t  = $realtobits(d3 * $bitstoreal(64'h3FE5555555555555));
      m_s  = $realtobits(d4 * $bitstoreal(64'h3FC5555555555555));
      m_cache_valid = 1'b1;
      e = '{1'b0, m_dt, m_h, m_t, m_s};
      exp_lat = 6 * mul_lat + 7; exp_muls = 6;
    end
    sb_q.push_back(e);
    m0  = mul_issued;
    ev0 = ev_count;
    do_start(dt);
    wait_event(ev0, 1000, "run");
    chk("latency",    W'(ev_cyc - t0 + 1),    W'(exp_lat));
    chk("mul_issues", W'(mul_issued - m0),    W'(exp_muls));
    $display("txn dt=%h L=%0d err=%0b lat=%0d muls=%0d", dt, mul_lat, e.is_err, ev_cyc - t0 + 1, mul_issued - m0);
  endtask

  logic [W-1:0] last_dt;
  logic [W-1:0] rnd;

  initial begin
    rst = 1'b1; start = 1'b0; delta_t_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_delta_t",   delta_t,   '0);
    chk("rst_half",      half_dt2,  '0);
    chk("rst_two3",      two3_dt3,  '0);
    chk("rst_sixth",     sixth_dt4, '0);
    chk("rst_busy",      W'(busy),      '0);
    chk("rst_valid_out", W'(valid_out), '0);
    chk("rst_err",       W'(err),       '0);
    $display("txn reset checked");
    rst = 1'b0;

    // dt = 2.0 miss, then hit
    mul_lat = 2;
    run(64'h4000000000000000);
    chk("c2_half",  half_dt2,  64'h4000000000000000);
    chk("c2_two3",  two3_dt3,  64'h4015555555555555);
    chk("c2_sixth", sixth_dt4, 64'h4005555555555555);
    run(64'h4000000000000000);

    // rejected inputs
    run(64'hC000000000000000);
    run(64'h7FF8000000000000);

    // stalled multiplier with extra starts while busy
    begin
      int m0, ev0;
      stall = 1'b1;
      sb_q.push_back('{1'b1, m_dt, m_h, m_t, m_s});
      m_cache_valid = 1'b0;
      m0  = mul_issued;
      ev0 = ev_count;
      do_start(64'h3FF0000000000000);
      repeat (4) begin
        @(negedge clk); start = 1'b1; delta_t_in = 64'h4008000000000000;
        @(negedge clk); start = 1'b0;
      end
      wait_event(ev0, 300, "mul_timeout");
      chk("stall_mul_issues", W'(mul_issued - m0), W'(1));
      $display("txn stalled run aborted after %0d cycles", ev_cyc - t0 + 1);
      stall = 1'b0;
      repeat (3) @(posedge clk);
    end
    run(64'h4000000000000000);

    // randomized traffic
    last_dt = 64'h4000000000000000;
    for (int n = 0; n < 24; n++) begin
      int r;
      mul_lat = $urandom_range(1, 4);
      r = $urandom_range(0, 9);
      rnd = {$urandom, $urandom};
      if (r < 2) begin
        run(last_dt);
      end else if (r == 2) begin
        run(r[0] ? {1'b1, rnd[62:0]} : {1'b0, 11'h7FF, rnd[51:0]});
      end else if (r == 3) begin
        last_dt = '0;
        run(last_dt);
      end else begin
        last_dt = {1'b0, 11'(991 + $urandom_range(0, 64)), rnd[51:0]};
        run(last_dt);
      end
    end

    // reset in the middle of op3
    begin
      int m0;
      mul_lat = 3;
      m0 = mul_issued;
      do_start(64'h4008000000000000);
      for (int i = 0; i < 200 && mul_issued < m0 + 4; i++) @(posedge clk);
      chk("mid_rst_reached_op3", W'(mul_issued - m0), W'(4));
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_delta_t", delta_t,   '0);
      chk("mid_rst_half",    half_dt2,  '0);
      chk("mid_rst_two3",    two3_dt3,  '0);
      chk("mid_rst_sixth",   sixth_dt4, '0);
      chk("mid_rst_busy",    W'(busy),  '0);
      rst = 1'b0;
      m_cache_valid = 1'b0;
      m_dt = '0; m_h = '0; m_t = '0; m_s = '0;
      $display("txn mid-run reset checked");
      repeat (10) @(posedge clk);
      run(64'h3FF0000000000000);
      chk("c1_half",  half_dt2,  64'h3FE0000000000000);
      chk("c1_two3",  two3_dt3,  64'h3FE5555555555555);
      chk("c1_sixth", sixth_dt4, 64'h3FC5555555555555);
    end

    repeat (5) @(posedge clk);
    chk("sb_drained", W'(sb_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
